// File: rtl/frag_buffer_mrw_pkg.sv
// frag_buffer_mrw_pkg: shared sizing for the fragment location buffer.
// Holds the location geometry, the lane counts, and the widths derived
// from them, so that the buffer, its storage and its clients agree.
package frag_buffer_mrw_pkg;
   localparam int DW              = 32;
   localparam int LOC_WIDTH       = 4 * DW;
   localparam int DEPTH           = 256;
   localparam int WR_LOCS         = 8;
   localparam int RD_LOCS         = 4;
   localparam int AF_THRESH       = 16;
   localparam int PTR_WIDTH       = $clog2(DEPTH);
   localparam int COUNT_WIDTH     = $clog2(DEPTH + 1);
   localparam int NO_LOC_WR_WIDTH = $clog2(WR_LOCS + 1);
   localparam int RD_NUM_WIDTH    = $clog2(RD_LOCS + 1);
endpackage

// File: rtl/frag_buffer_mem.sv
// frag_buffer_mem: DEPTH x LOC_WIDTH location store.
//   clk        : clock
//   we_i       : write strobe for the whole burst
//   wr_base_i  : address of write lane 0
//   wr_num_i   : number of lanes (from lane 0) actually stored
//   wr_data_i  : WR_LOCS write lanes
//   rd_base_i  : address of read lane 0
//   rd_data_o  : RD_LOCS asynchronous read lanes (unmasked)
// Lane addresses are base + lane index with natural PTR_WIDTH wrap, so
// bursts straddling the top of the array continue at location 0.
module frag_buffer_mem
   import frag_buffer_mrw_pkg::*;
#(
   parameter int LW  = LOC_WIDTH,
   parameter int DP  = DEPTH,
   parameter int WRL = WR_LOCS,
   parameter int RDL = RD_LOCS,
   parameter int PW  = $clog2(DP),
   parameter int NW  = $clog2(WRL + 1)
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [PW-1:0]            wr_base_i,
   input  logic [NW-1:0]            wr_num_i,
   input  logic [WRL-1:0][LW-1:0]   wr_data_i,
   input  logic [PW-1:0]            rd_base_i,
   output logic [RDL-1:0][LW-1:0]   rd_data_o
);
   logic [LW-1:0] mem_q [DP];

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int i = 0; i < WRL; i++) begin
            if (i < int'(wr_num_i)) mem_q[wr_base_i + PW'(i)] <= wr_data_i[i];
         end
      end
   end

   for (genvar k = 0; k < RDL; k++) begin : g_rd
      assign rd_data_o[k] = mem_q[rd_base_i + PW'(k)];
   end
endmodule

// File: rtl/frag_buffer_mrw.sv
// frag_buffer_mrw: circular multi-read/multi-write location buffer between
// the TX arbiter (writer) and the fragmentation engine (reader).
//   clk, arst    : clock, async active-low reset
//   flush        : synchronous clear of pointers/count (beats wr_en/rd_en)
//   wr_en, no_loc_wr, data_in : write 1..WR_LOCS locations, lane 0 at LSBs
//   empty_loc, almost_full    : free space and low-space flag
//   rd_en, rd_num             : pop 1..RD_LOCS locations
//   rd_data, rd_valid, count  : show-ahead head lanes, lane validity, fill
//   wr_err, rd_err            : one-cycle pulses for rejected requests
// Both requests are admitted against the count at the start of the cycle,
// so space freed by a same-cycle pop is not offered to that cycle's write.
module frag_buffer_mrw
   import frag_buffer_mrw_pkg::*;
#(
   parameter int LW   = LOC_WIDTH,
   parameter int DP   = DEPTH,
   parameter int WRL  = WR_LOCS,
   parameter int RDL  = RD_LOCS,
   parameter int AFT  = AF_THRESH,
   localparam int PW  = $clog2(DP),
   localparam int CW  = $clog2(DP + 1),
   localparam int NW  = $clog2(WRL + 1),
   localparam int RW  = $clog2(RDL + 1)
) (
   input  logic                 clk,
   input  logic                 arst,
   input  logic                 flush,
   input  logic                 wr_en,
   input  logic [NW-1:0]        no_loc_wr,
   input  logic [WRL*LW-1:0]    data_in,
   output logic [CW-1:0]        empty_loc,
   output logic                 almost_full,
   input  logic                 rd_en,
   input  logic [RW-1:0]        rd_num,
   output logic [RDL*LW-1:0]    rd_data,
   output logic [RDL-1:0]       rd_valid,
   output logic [CW-1:0]        count,
   output logic                 wr_err,
   output logic                 rd_err
);
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          wr_err_q, wr_err_d, rd_err_q, rd_err_d;
   logic [CW-1:0] wr_n, rd_n;
   logic          wr_ok, rd_ok;
   logic [RDL-1:0][LW-1:0] raw_lanes, lanes;

   assign empty_loc   = CW'(DP) - count_q;
   assign almost_full = empty_loc < CW'(AFT);
   assign count       = count_q;
   assign wr_err      = wr_err_q;
   assign rd_err      = rd_err_q;

   assign wr_n  = CW'(no_loc_wr);
   assign rd_n  = CW'(rd_num);
   assign wr_ok = wr_en && (wr_n != '0) && (wr_n <= CW'(WRL)) && (wr_n <= empty_loc);
   assign rd_ok = rd_en && (rd_n != '0) && (rd_n <= CW'(RDL)) && (rd_n <= count_q);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      wr_err_d = 1'b0;
      rd_err_d = 1'b0;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_ok)      wr_ptr_d = wr_ptr_q + PW'(no_loc_wr);
         else if (wr_en) wr_err_d = 1'b1;
         if (rd_ok)      rd_ptr_d = rd_ptr_q + PW'(rd_num);
         else if (rd_en) rd_err_d = 1'b1;
         count_d = count_q + (wr_ok ? wr_n : '0) - (rd_ok ? rd_n : '0);
      end
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         wr_err_q <= 1'b0;
         rd_err_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         wr_err_q <= wr_err_d;
         rd_err_q <= rd_err_d;
      end
   end

   // A flushed cycle must not leave stray data behind the reset pointers.
   frag_buffer_mem #(
      .LW(LW), .DP(DP), .WRL(WRL), .RDL(RDL), .PW(PW), .NW(NW)
   ) u_mem (
      .clk      (clk),
      .we_i     (wr_ok && !flush),
      .wr_base_i(wr_ptr_q),
      .wr_num_i (no_loc_wr),
      .wr_data_i(data_in),
      .rd_base_i(rd_ptr_q),
      .rd_data_o(raw_lanes)
   );

   for (genvar k = 0; k < RDL; k++) begin : g_lane
      assign rd_valid[k] = count_q > CW'(k);
      assign lanes[k]    = rd_valid[k] ? raw_lanes[k] : '0;
   end
   assign rd_data = lanes;
endmodule

// File: tb/tb_frag_buffer_mrw.sv
module tb_frag_buffer_mrw;
   logic          clk = 1'b0;
   logic          arst;
   logic          flush, wr_en, rd_en;
   logic [3:0]    no_loc_wr;
   logic [2:0]    rd_num;
   logic [1023:0] data_in;
   logic [8:0]    empty_loc, count;
   logic          almost_full, wr_err, rd_err;
   logic [511:0]  rd_data;
   logic [3:0]    rd_valid;

   int checks = 0;
   int failures = 0;

   frag_buffer_mrw dut (
      .clk(clk), .arst(arst), .flush(flush), .wr_en(wr_en),
      .no_loc_wr(no_loc_wr), .data_in(data_in), .empty_loc(empty_loc),
      .almost_full(almost_full), .rd_en(rd_en), .rd_num(rd_num),
      .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
      .wr_err(wr_err), .rd_err(rd_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         fl;
      logic         we;
      logic [3:0]   nw;
      int           seed;
      logic         re;
      logic [2:0]   nr;
      int           ecount;
      logic [3:0]   evalid;
      logic         ewerr;
      logic         ererr;
      logic [511:0] edata;
   } vec_t;

   vec_t tv[14];

   function automatic logic [127:0] mk(input int seed, input int i);
      logic [15:0] s, n;
      s = seed[15:0];
      n = i[15:0];
      return {4{s, n}};
   endfunction

   function automatic logic [511:0] L(input logic [127:0] d3, d2, d1, d0);
      return {d3, d2, d1, d0};
   endfunction

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic op(input logic fl, input logic we, input logic [3:0] nw, input int seed,
                     input logic re, input logic [2:0] nr);
      @(negedge clk);
      flush = fl; wr_en = we; no_loc_wr = nw; rd_en = re; rd_num = nr;
      for (int i = 0; i < 8; i++) data_in[i*128 +: 128] = mk(seed, i);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string nm, input int ecount, input logic [3:0] evalid,
                            input logic ewerr, input logic ererr);
      chk({nm, "_count"}, 512'(count), 512'(ecount));
      chk({nm, "_empty"}, 512'(empty_loc), 512'(256 - ecount));
      chk({nm, "_afull"}, 512'(almost_full), 512'(ecount > 240));
      chk({nm, "_valid"}, 512'(rd_valid), 512'(evalid));
      chk({nm, "_wr_err"}, 512'(wr_err), 512'(ewerr));
      chk({nm, "_rd_err"}, 512'(rd_err), 512'(ererr));
   endtask

   initial begin
      arst = 1'b0; flush = 0; wr_en = 0; rd_en = 0; no_loc_wr = 0; rd_num = 0; data_in = '0;
      tv[0]  = '{0, 1, 3, 1, 0, 0, 3, 4'b0111, 0, 0, L(0, mk(1,2), mk(1,1), mk(1,0))};
      tv[1]  = '{0, 0, 0, 0, 1, 2, 1, 4'b0001, 0, 0, L(0, 0, 0, mk(1,2))};
      tv[2]  = '{0, 0, 0, 0, 1, 2, 1, 4'b0001, 0, 1, L(0, 0, 0, mk(1,2))};
      tv[3]  = '{0, 0, 0, 0, 0, 0, 1, 4'b0001, 0, 0, L(0, 0, 0, mk(1,2))};
      tv[4]  = '{0, 1, 0, 9, 0, 0, 1, 4'b0001, 1, 0, L(0, 0, 0, mk(1,2))};
      tv[5]  = '{0, 1, 9, 5, 0, 0, 1, 4'b0001, 1, 0, L(0, 0, 0, mk(1,2))};
      tv[6]  = '{0, 0, 0, 0, 1, 0, 1, 4'b0001, 0, 1, L(0, 0, 0, mk(1,2))};
      tv[7]  = '{0, 0, 0, 0, 1, 5, 1, 4'b0001, 0, 1, L(0, 0, 0, mk(1,2))};
      tv[8]  = '{0, 1, 4, 2, 1, 1, 4, 4'b1111, 0, 0, L(mk(2,3), mk(2,2), mk(2,1), mk(2,0))};
      tv[9]  = '{0, 1, 1, 3, 0, 0, 5, 4'b1111, 0, 0, L(mk(2,3), mk(2,2), mk(2,1), mk(2,0))};
      tv[10] = '{0, 1, 4, 4, 1, 2, 7, 4'b1111, 0, 0, L(mk(4,0), mk(3,0), mk(2,3), mk(2,2))};
      tv[11] = '{1, 1, 0, 6, 1, 0, 0, 4'b0000, 0, 0, '0};
      tv[12] = '{0, 1, 2, 6, 0, 0, 2, 4'b0011, 0, 0, L(0, 0, mk(6,1), mk(6,0))};
      tv[13] = '{0, 0, 0, 0, 1, 2, 0, 4'b0000, 0, 0, '0};

      // Reset state
      #12;
      chk_state("reset", 0, 4'b0000, 0, 0);
      chk("reset_rd_data", rd_data, '0);
      @(negedge clk);
      arst = 1'b1;

      // Single-cycle directed vectors
      for (int v = 0; v < 14; v++) begin
         op(tv[v].fl, tv[v].we, tv[v].nw, tv[v].seed, tv[v].re, tv[v].nr);
         chk_state($sformatf("v%0d", v), tv[v].ecount, tv[v].evalid, tv[v].ewerr, tv[v].ererr);
         chk($sformatf("v%0d_rd_data", v), rd_data, tv[v].edata);
      end

      // Fill to 254, then reject an oversize write
      op(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 31; k++) op(0, 1, 8, 16 + k, 0, 0);
      op(0, 1, 6, 47, 0, 0);
      chk_state("fill254", 254, 4'b1111, 0, 0);
      chk("fill254_lane0", 512'(rd_data[127:0]), 512'(mk(16, 0)));
      op(0, 1, 3, 50, 0, 0);
      chk_state("fill_over", 254, 4'b1111, 1, 0);

      // Drain 254 so both pointers sit at 254
      for (int k = 0; k < 63; k++) op(0, 0, 0, 0, 1, 4);
      op(0, 0, 0, 0, 1, 2);
      chk_state("drain", 0, 4'b0000, 0, 0);

      // Wrap: 254,255,0,1
      op(0, 1, 4, 'h77, 0, 0);
      chk_state("wrap_wr", 4, 4'b1111, 0, 0);
      chk("wrap_wr_data", rd_data, L(mk('h77,3), mk('h77,2), mk('h77,1), mk('h77,0)));
      op(0, 0, 0, 0, 1, 4);
      chk_state("wrap_rd", 0, 4'b0000, 0, 0);
      op(0, 1, 1, 'h88, 0, 0);
      chk_state("post_wrap", 1, 4'b0001, 0, 0);
      chk("post_wrap_data", rd_data, L(0, 0, 0, mk('h88, 0)));
      op(0, 0, 0, 0, 1, 1);

      // Fill to completely full, then boundary rejections
      for (int k = 0; k < 32; k++) op(0, 1, 8, 'h100 + k, 0, 0);
      chk_state("full", 256, 4'b1111, 0, 0);
      chk("full_lane0", 512'(rd_data[127:0]), 512'(mk('h100, 0)));
      op(0, 1, 1, 'h200, 0, 0);
      chk_state("full_wr", 256, 4'b1111, 1, 0);
      op(0, 1, 1, 'h201, 1, 1);
      chk_state("full_wr_rd", 255, 4'b1111, 1, 0);
      chk("full_wr_rd_lane0", 512'(rd_data[127:0]), 512'(mk('h100, 1)));
      op(0, 0, 0, 0, 0, 0);
      chk_state("idle", 255, 4'b1111, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/frag_buffer_mrw.md
Name: frag_buffer_mrw

Overview:
- Parametrised circular location buffer between the TX arbiter (writer) and the data-fragmentation engine (reader).
- Generalises the fixed two-location read to a variable 1..RD_LOCS read per cycle and a 1..WR_LOCS write per cycle.
- Adds per-lane read-valid masking, overflow/underflow error flags, an almost-full threshold and a synchronous flush.
- Storage is show-ahead: head locations are always visible on the read lanes without a read request.

Parameters:
- DW, 32, dword width in bits
- LOC_WIDTH, 4*DW, bits per location
- DEPTH, 256, number of locations; must be a power of two
- WR_LOCS, 8, maximum locations written per cycle
- RD_LOCS, 4, maximum locations read per cycle
- AF_THRESH, 16, almost_full asserts when empty_loc < AF_THRESH

Ports:
- clk  in  1  clock
- arst  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of buffer contents
- wr_en  in  1  write request
- no_loc_wr  in  $clog2(WR_LOCS+1)  locations to write
- data_in  in  WR_LOCS*LOC_WIDTH  lane 0 at LSBs
- empty_loc  out  $clog2(DEPTH+1)  free locations
- almost_full  out  1  free space below threshold
- rd_en  in  1  pop request
- rd_num  in  $clog2(RD_LOCS+1)  locations to pop
- rd_data  out  RD_LOCS*LOC_WIDTH  lane k = mem[rd_ptr+k]
- rd_valid  out  RD_LOCS  bit k = (k < count)
- count  out  $clog2(DEPTH+1)  stored locations
- wr_err  out  1  one-cycle pulse, write rejected
- rd_err  out  1  one-cycle pulse, read rejected

Behaviour:
- Reset (arst=0, async): wr_ptr=rd_ptr=0, count=0, empty_loc=DEPTH, almost_full=(DEPTH<AF_THRESH), wr_err=rd_err=0, rd_valid=0, rd_data=0. Memory is not reset.
- empty_loc = DEPTH - count, combinational from registered count.
- Write is legal when wr_en=1, 1<=no_loc_wr<=WR_LOCS, and no_loc_wr<=empty_loc, using the pre-cycle count.
  - Legal write: data_in lanes 0..no_loc_wr-1 go to mem[(wr_ptr+i) mod DEPTH]; wr_ptr += no_loc_wr.
  - Illegal write (including no_loc_wr=0): nothing stored, wr_err=1 next cycle.
- Read is legal when rd_en=1, 1<=rd_num<=RD_LOCS, and rd_num<=count, using the pre-cycle count.
  - Legal read: rd_ptr += rd_num.
  - Illegal read: no pop, rd_err=1 next cycle.
- Same-cycle write and read: both evaluated against the pre-cycle count; count_next = count + wr_n - rd_n.
  - Space freed by a same-cycle read is not usable by that cycle's write.
  - Data written this cycle appears on rd_data the following cycle, never the same cycle; no bypass.
- Read lanes are combinational from rd_ptr and mem. Lanes with rd_valid[k]=0 are driven to 0.
- Pointer arithmetic is modulo DEPTH, with log2(DEPTH)-bit natural wrap. Multi-location writes and reads may straddle DEPTH-1 -> 0.
- Flush has priority over wr_en/rd_en in the same cycle: pointers and count go to 0 next cycle and no error flags are raised.
- Errors are single-cycle pulses and are non-sticky.
- No state machine beyond pointer/count registers.
- Latency: write-to-visible is 1 cycle; pop-to-next-head is 1 cycle.

Decomposition:
- data_frag_package holds DW, LOC_WIDTH, DEPTH, WR_LOCS, RD_LOCS, and the derived PTR_WIDTH, COUNT_WIDTH, NO_LOC_WR_WIDTH, RD_NUM_WIDTH.
- Existing buffer_frag_interface gains a parametrised modport set: buffer, arbiter_buffer, frag_engine, buffer_tb.
- Sub-module frag_buffer_mem: DEPTH x LOC_WIDTH array with WR_LOCS masked write lanes (base address + lane offset, wrap) and RD_LOCS async read lanes.
- Top frag_buffer_mrw holds the pointers, count, admission logic and flags.

Test Plan:
- Reset -> count=0, empty_loc=256, rd_valid=4'b0000, rd_data=0, wr_err=rd_err=0.
- Write 3 locations {A,B,C} -> next cycle: count=3, empty_loc=253, rd_valid=4'b0111, lanes 0..2 = A,B,C, lane 3 = 0.
- With count=3, rd_en, rd_num=2 -> next cycle: count=1, lane0=C, rd_valid=4'b0001. Then rd_num=2 -> rd_err pulse, count stays 1.
- Fill to count=254, write no_loc_wr=3 -> wr_err pulse, count=254. Write 2 -> count=256, empty_loc=0, almost_full=1.
- Wrap: wr_ptr=rd_ptr=254, count=0, write 4 {W0..W3} -> stored at 254,255,0,1. Read 4 -> lanes W0..W3, rd_ptr=2.
- count=5, same cycle write 4 and read 2 -> count=7. Then flush with wr_en=1 -> count=0, empty_loc=256, no wr_err.
